// File: rtl/output_row_streamer.sv
// Row readout: buffers whole pixel rows in a DEPTH-slot ring and serialises
// each row onto a narrow valid/ready bus with framing and overflow flags.
module output_row_streamer #(
   parameter int ARRAY_WIDTH = 8,
   parameter int BUS_PIXELS  = 2,
   parameter int PIXEL_BITS  = 10,
   parameter int DEPTH       = 2,
   localparam int BEATS      = ARRAY_WIDTH / BUS_PIXELS,
   localparam int BEAT_BITS  = (BEATS > 1) ? $clog2(BEATS) : 1,
   localparam int CNT_BITS   = $clog2(DEPTH + 1)
) (
   input  logic                               CLK,
   input  logic                               RESET,
   input  logic                               ROW_VALID,
   input  logic                               ROW_LAST,
   input  logic [ARRAY_WIDTH*PIXEL_BITS-1:0]  DATA_IN,
   output logic                               ROW_READY,
   output logic                               OUT_VALID,
   input  logic                               OUT_READY,
   output logic [BUS_PIXELS*PIXEL_BITS-1:0]   DATA_OUT,
   output logic                               OUT_FIRST,
   output logic                               OUT_LAST,
   output logic                               OUT_EOF,
   output logic                               OVERFLOW,
   input  logic                               CLEAR_FLAGS,
   output logic [CNT_BITS-1:0]                ROWS_PENDING
);

   localparam int ROW_W      = ARRAY_WIDTH * PIXEL_BITS;
   localparam int BEAT_W     = BUS_PIXELS * PIXEL_BITS;
   localparam int PTR_BITS   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int SLOTS      = 1 << PTR_BITS;
   localparam int BEAT_SLOTS = 1 << BEAT_BITS;

   typedef enum logic {IDLE, STREAM} state_t;

   state_t               state, state_nxt;
   logic [ROW_W-1:0]     row_mem [SLOTS];
   logic [SLOTS-1:0]     tag_mem;
   logic [PTR_BITS-1:0]  wr_ptr, rd_ptr;
   logic [CNT_BITS-1:0]  count, count_nxt;
   logic [BEAT_BITS-1:0] beat;
   logic                 overflow;
   logic                 row_ready, capture, drop, streaming, xfer, last_beat, rel_row;
   logic [BEAT_W-1:0]    beat_data [BEAT_SLOTS];

   function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
      return (p == PTR_BITS'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign row_ready = (count != CNT_BITS'(DEPTH));
   assign capture   = ROW_VALID && row_ready;
   assign drop      = ROW_VALID && !row_ready;
   assign streaming = (state == STREAM);
   assign xfer      = streaming && OUT_READY;
   assign last_beat = (beat == BEAT_BITS'(BEATS - 1));
   assign rel_row   = xfer && last_beat;

   always_comb begin
      count_nxt = count;
      if (capture && !rel_row)
         count_nxt = count + 1'b1;
      else if (!capture && rel_row)
         count_nxt = count - 1'b1;
   end

   // A row captured on the releasing edge counts as still stored: no bubble.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (count != '0) state_nxt = STREAM;
         STREAM:  if (rel_row && count_nxt == '0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         beat     <= '0;
         overflow <= 1'b0;
         tag_mem  <= '0;
         for (int unsigned i = 0; i < SLOTS; i++)
            row_mem[i] <= '0;
      end else begin
         count <= count_nxt;
         if (capture) begin
            row_mem[wr_ptr] <= DATA_IN;
            tag_mem[wr_ptr] <= ROW_LAST;
            wr_ptr          <= ptr_inc(wr_ptr);
         end
         if (rel_row) begin
            rd_ptr <= ptr_inc(rd_ptr);
            beat   <= '0;
         end else if (xfer) begin
            beat <= beat + 1'b1;
         end
         if (drop)
            overflow <= 1'b1;
         else if (CLEAR_FLAGS)
            overflow <= 1'b0;
      end
   end

   // Beat table padded to a power of two so the beat counter indexes it exactly.
   always_comb begin
      for (int unsigned b = 0; b < BEAT_SLOTS; b++)
         beat_data[b] = '0;
      for (int unsigned b = 0; b < BEATS; b++)
         beat_data[b] = row_mem[rd_ptr][b*BEAT_W +: BEAT_W];
   end

   assign ROW_READY    = row_ready;
   assign OUT_VALID    = streaming;
   assign DATA_OUT     = streaming ? beat_data[beat] : '0;
   assign OUT_FIRST    = streaming && (beat == '0);
   assign OUT_LAST     = streaming && last_beat;
   assign OUT_EOF      = streaming && last_beat && tag_mem[rd_ptr];
   assign OVERFLOW     = overflow;
   assign ROWS_PENDING = count;

endmodule
